// File: rtl/fifo_pkg.sv
// fifo_pkg: shared width/capacity derivation and pointer-compare helpers for the level FIFO.
// Pointers carry one extra wrap bit so all 2**depth slots are usable.
package fifo_pkg;
    function automatic int ptr_w(input int depth);
        return depth + 1;
    endfunction

    function automatic int cap(input int depth);
        return 1 << depth;
    endfunction

    // Full when wrap bits differ and the addresses match.
    function automatic logic ptr_full(input logic [31:0] wr, input logic [31:0] rd, input int depth);
        logic [31:0] m;
        m = (32'd1 << depth) - 32'd1;
        return (((wr ^ rd) & m) == 32'd0) && ((((wr ^ rd) >> depth) & 32'd1) != 32'd0);
    endfunction

    function automatic logic ptr_empty(input logic [31:0] wr, input logic [31:0] rd);
        return wr == rd;
    endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: storage array, one synchronous write port and one asynchronous read port.
// Ports: i_clk clock; i_we_w/i_waddr_w/i_wdata_w write port; i_raddr_w/o_rdata_w read port.
// Contents are never cleared.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             i_clk,
    input  logic             i_we_w,
    input  logic [AW-1:0]    i_waddr_w,
    input  logic [WIDTH-1:0] i_wdata_w,
    input  logic [AW-1:0]    i_raddr_w,
    output logic [WIDTH-1:0] o_rdata_w
);
    logic [WIDTH-1:0] r_mem [2**AW];

    always_ff @(posedge i_clk)
        if (i_we_w) r_mem[i_waddr_w] <= i_wdata_w;

    assign o_rdata_w = r_mem[i_raddr_w];
endmodule

// File: rtl/fifo_lvl.sv
// fifo_lvl: single-clock FWFT FIFO with occupancy count, runtime almost-full/almost-empty
// thresholds, overflow/underflow pulses and an optional high-water mark (macro FIFO_PEAK_EN).
// Ports: i_clk clock; i_reset_w sync active-high reset; i_data_w/i_write_w write side;
// i_read_w pop; i_afull_lvl_w/i_aempty_lvl_w thresholds; i_peak_clr_w peak clear;
// o_data_w head entry (0 when empty); o_count_w occupancy; o_full_w/o_empty_w/o_afull_w/o_aempty_w
// flags; o_overflow_w/o_underflow_w one-cycle error pulses; o_peak_w high-water mark.
module fifo_lvl
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_w,
    input  logic [FIFO_WIDTH-1:0] i_data_w,
    input  logic                  i_write_w,
    input  logic                  i_read_w,
    input  logic [FIFO_DEPTH:0]   i_afull_lvl_w,
    input  logic [FIFO_DEPTH:0]   i_aempty_lvl_w,
    input  logic                  i_peak_clr_w,
    output logic [FIFO_WIDTH-1:0] o_data_w,
    output logic [FIFO_DEPTH:0]   o_count_w,
    output logic                  o_full_w,
    output logic                  o_empty_w,
    output logic                  o_afull_w,
    output logic                  o_aempty_w,
    output logic                  o_overflow_w,
    output logic                  o_underflow_w,
    output logic [FIFO_DEPTH:0]   o_peak_w
);
    localparam int PW = ptr_w(FIFO_DEPTH);

    logic [PW-1:0]         r_wr_ptr, r_rd_ptr, r_count;
    logic                  r_overflow, r_underflow;
    logic                  w_full, w_empty, w_wr_acc, w_rd_acc;
    logic [PW-1:0]         w_next_count;
    logic [FIFO_WIDTH-1:0] w_rd_data;

    assign w_full       = ptr_full(32'(r_wr_ptr), 32'(r_rd_ptr), FIFO_DEPTH);
    assign w_empty      = ptr_empty(32'(r_wr_ptr), 32'(r_rd_ptr));
    // A read frees the slot in the same edge, so a full FIFO still takes a paired write.
    assign w_wr_acc     = i_write_w && (!w_full || i_read_w);
    assign w_rd_acc     = i_read_w && !w_empty;
    assign w_next_count = r_count + PW'(w_wr_acc) - PW'(w_rd_acc);

    fifo_mem #(.WIDTH(FIFO_WIDTH), .AW(FIFO_DEPTH)) u_mem (
        .i_clk     (i_clk),
        .i_we_w    (w_wr_acc),
        .i_waddr_w (r_wr_ptr[FIFO_DEPTH-1:0]),
        .i_wdata_w (i_data_w),
        .i_raddr_w (r_rd_ptr[FIFO_DEPTH-1:0]),
        .o_rdata_w (w_rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset_w) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr    <= r_wr_ptr + PW'(w_wr_acc);
            r_rd_ptr    <= r_rd_ptr + PW'(w_rd_acc);
            r_count     <= w_next_count;
            r_overflow  <= i_write_w && w_full && !i_read_w;
            r_underflow <= i_read_w && w_empty;
        end
    end

    assign o_data_w      = w_empty ? '0 : w_rd_data;
    assign o_count_w     = r_count;
    assign o_full_w      = w_full;
    assign o_empty_w     = w_empty;
    assign o_afull_w     = r_count >= i_afull_lvl_w;
    assign o_aempty_w    = r_count <= i_aempty_lvl_w;
    assign o_overflow_w  = r_overflow;
    assign o_underflow_w = r_underflow;

`ifdef FIFO_PEAK_EN
    logic [PW-1:0] r_peak;

    always_ff @(posedge i_clk) begin
        if (i_reset_w) r_peak <= '0;
        else if (i_peak_clr_w || (w_next_count > r_peak)) r_peak <= w_next_count;
    end

    assign o_peak_w = r_peak;
`else
    logic w_unused;
    assign w_unused = i_peak_clr_w;
    assign o_peak_w = '0;
`endif
endmodule

// File: tb/tb_fifo_lvl.sv
// tb_fifo_lvl: directed plus randomized checks of fifo_lvl against a queue-based model.
module tb_fifo_lvl;
    localparam int W = 8;
    localparam int D = 3;
    localparam int CAP = 8;

    logic         clk = 1'b0;
    logic         rst, wr, rd, clr;
    logic [W-1:0] din;
    logic [D:0]   afl, ael;
    logic [W-1:0] dout;
    logic [D:0]   cnt, peak;
    logic         full, empty, afull, aempty, ovf, unf;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q[$];
    int m_peak = 0;
    int m_ovf = 0;
    int m_unf = 0;

    always #5 clk = ~clk;

    fifo_lvl #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .i_clk          (clk),
        .i_reset_w      (rst),
        .i_data_w       (din),
        .i_write_w      (wr),
        .i_read_w       (rd),
        .i_afull_lvl_w  (afl),
        .i_aempty_lvl_w (ael),
        .i_peak_clr_w   (clr),
        .o_data_w       (dout),
        .o_count_w      (cnt),
        .o_full_w       (full),
        .o_empty_w      (empty),
        .o_afull_w      (afull),
        .o_aempty_w     (aempty),
        .o_overflow_w   (ovf),
        .o_underflow_w  (unf),
        .o_peak_w       (peak)
    );

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count", int'(cnt), n);
        chk("full", int'(full), int'(n == CAP));
        chk("empty", int'(empty), int'(n == 0));
        chk("afull", int'(afull), int'(n >= int'(afl)));
        chk("aempty", int'(aempty), int'(n <= int'(ael)));
        chk("overflow", int'(ovf), m_ovf);
        chk("underflow", int'(unf), m_unf);
        chk("data", int'(dout), n > 0 ? int'(q[0]) : 0);
`ifdef FIFO_PEAK_EN
        chk("peak", int'(peak), m_peak);
`else
        chk("peak", int'(peak), 0);
`endif
    endtask

    // One clock: drive inputs, advance the model by the FIFO rules, then check outputs.
    task automatic step(input logic w, input logic r, input logic [W-1:0] d,
                        input logic c = 1'b0, input logic rs = 1'b0);
        int n;
        wr = w; rd = r; din = d; clr = c; rst = rs;
        @(posedge clk);
        n = q.size();
        if (rs) begin
            q.delete();
            m_peak = 0; m_ovf = 0; m_unf = 0;
        end else begin
            m_ovf = int'(w && n == CAP && !r);
            m_unf = int'(r && n == 0);
            if (r && n > 0) void'(q.pop_front());
            if (w && (n < CAP || r)) q.push_back(d);
            if (c || q.size() > m_peak) m_peak = q.size();
        end
        #1;
        check_all();
    endtask

    initial begin
        afl = 4'd6; ael = 4'd2;
        step(0, 0, 0, 0, 1);
        for (int i = 1; i <= 8; i++) step(1, 0, W'(8'h11 * i));
        step(1, 0, 8'h99);
        step(0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 1, 0);
        step(0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 5; i++) step(1, 0, W'(16 * k + i + 1));
            for (int i = 0; i < 5; i++) step(0, 1, 0);
        end
        for (int i = 1; i <= 8; i++) step(1, 0, W'(8'h11 * i));
        step(1, 1, 8'hAA);
        for (int i = 0; i < 8; i++) step(0, 1, 0);
        step(1, 1, 8'h55);
        for (int i = 0; i < 8; i++) step(1, 0, W'(i));
        afl = 4'd9;
        #1;
        chk("afull_lvl9", int'(afull), 0);
        afl = 4'd0;
        #1;
        chk("afull_lvl0", int'(afull), 1);
        afl = 4'd6;
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) step(1, 0, W'(i + 3));
        for (int i = 0; i < 5; i++) step(0, 1, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, W'(i));
        step(1, 1, 8'h77, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) begin
                afl = D'($urandom_range(15));
                ael = D'($urandom_range(15));
            end
            step(1'($urandom_range(99) < 55), 1'($urandom_range(99) < 50), W'($urandom),
                 1'($urandom_range(49) == 0), 1'($urandom_range(199) == 0));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
